// File: rtl/uart_echo_buffer.sv
// Byte FIFO plus transmit sequencer sitting between the UART receiver and transmitter.
// Received bytes are queued and replayed in order, one per transmitter start/done handshake.
module uart_echo_buffer #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Empty,
    output logic              o_Full,
    output logic              o_Overflow
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_STEP   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;
    logic              r_overflow;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // A pop frees the head slot on the same edge, so a full FIFO can still accept a byte then.
    always_comb begin
        w_pop  = (r_state == IDLE) && (r_count != '0) && !i_Tx_Active;
        w_push = i_Rx_DV && ((r_count != FULL_COUNT) || w_pop);
        w_drop = i_Rx_DV && (r_count == FULL_COUNT) && !w_pop;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_pop) w_state_next = LAUNCH;
            LAUNCH:    w_state_next = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_tx_dv <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_STEP;
            end
            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_STEP;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_STEP;
                2'b01:   r_count <= r_count - CNT_STEP;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_Tx_DV    = r_tx_dv;
    assign o_Tx_Byte  = r_tx_byte;
    assign o_Count    = r_count;
    assign o_Empty    = (r_count == '0);
    assign o_Full     = (r_count == FULL_COUNT);
    assign o_Overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: queue-based reference model compared every cycle,
// a simple transmitter model, directed scenarios and a randomized soak.
module tb_uart_echo_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_Rx_DV = 1'b0;
    logic [7:0]        i_Rx_Byte = 8'h00;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic [ADDR_W:0]   o_Count;
    logic              o_Empty;
    logic              o_Full;
    logic              o_Overflow;

    // transmitter model and stimulus overrides
    logic   tx_busy = 1'b0;
    logic   tx_done = 1'b0;
    logic   force_active = 1'b0;
    logic   spur_done = 1'b0;
    int     tx_cnt = 0;
    int     frame_len = 6;
    logic [7:0] emitted[$];

    // reference model
    logic [7:0] m_q[$];
    logic       m_dv = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_pop = 1'b0;
    int         m_phase = 0;   // 0: free to launch, 1: just launched, 2: awaiting done

    int n_checks = 0;
    int n_errors = 0;

    assign i_Tx_Active = tx_busy | force_active;
    assign i_Tx_Done   = tx_done | spur_done;

    always #5 clk = ~clk;

    uart_echo_buffer #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .o_Count     (o_Count),
        .o_Empty     (o_Empty),
        .o_Full      (o_Full),
        .o_Overflow  (o_Overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue; a launch needs a free handshake, a non-empty queue and an idle transmitter.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_dv = 1'b0; m_byte = 8'h00; m_ovf = 1'b0; m_phase = 0;
            end else begin
                m_pop = (m_phase == 0) && (m_q.size() > 0) && !i_Tx_Active;
                m_dv  = m_pop;
                if (m_phase == 1) m_phase = 2;
                else if (m_phase == 2 && i_Tx_Done) m_phase = 0;
                if (m_pop) begin
                    m_byte  = m_q.pop_front();
                    m_phase = 1;
                end
                if (i_Rx_DV) begin
                    if (m_q.size() < DEPTH) m_q.push_back(i_Rx_Byte);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("tx_dv",    int'(o_Tx_DV),    int'(m_dv));
                check("tx_byte",  int'(o_Tx_Byte),  int'(m_byte));
                check("count",    int'(o_Count),    m_q.size());
                check("empty",    int'(o_Empty),    int'(m_q.size() == 0));
                check("full",     int'(o_Full),     int'(m_q.size() == DEPTH));
                check("overflow", int'(o_Overflow), int'(m_ovf));
            end
        end
    end

    // Transmitter: goes busy on a start pulse, pulses done after frame_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                tx_busy = 1'b0;
                tx_cnt  = 0;
            end else if (tx_busy) begin
                tx_cnt--;
                if (tx_cnt <= 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (o_Tx_DV) begin
                tx_busy = 1'b1;
                tx_cnt  = frame_len;
                emitted.push_back(o_Tx_Byte);
                $display("tx byte %02h at %0t", o_Tx_Byte, $time);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(negedge clk);
        i_Rx_DV   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(m_q.size() == 0 && m_phase == 0 && !tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", m_q.size());
        end
    endtask

    task automatic check_emitted(input string name, input int start, input logic [7:0] exp[$]);
        check({name, "_len"}, emitted.size() - start, exp.size());
        for (int i = 0; i < exp.size() && start + i < emitted.size(); i++) begin
            check(name, int'(emitted[start+i]), int'(exp[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp[$];
        int start;
        int pulses;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_tx_dv",   int'(o_Tx_DV), 0);
        check("rst_tx_byte", int'(o_Tx_Byte), 8'h00);
        check("rst_count",   int'(o_Count), 0);
        check("rst_empty",   int'(o_Empty), 1);
        check("rst_full",    int'(o_Full), 0);
        check("rst_ovf",     int'(o_Overflow), 0);

        // single byte, transmitter idle
        start = emitted.size();
        push_byte(8'h55);
        check("single_count_after_push", int'(o_Count), 1);
        check("single_dv_before",        int'(o_Tx_DV), 0);
        @(negedge clk);
        check("single_dv",    int'(o_Tx_DV), 1);
        check("single_byte",  int'(o_Tx_Byte), 8'h55);
        check("single_empty", int'(o_Empty), 1);
        @(negedge clk);
        check("single_dv_drop", int'(o_Tx_DV), 0);
        drain(200);
        exp = '{8'h55};
        check_emitted("single_emit", start, exp);

        // ordered burst while the transmitter is held busy
        start = emitted.size();
        force_active = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'(i));
        check("burst_count", int'(o_Count), 4);
        check("burst_no_dv", int'(o_Tx_DV), 0);
        force_active = 1'b0;
        drain(500);
        exp = '{8'h00, 8'h01, 8'h02, 8'h03};
        check_emitted("burst_emit", start, exp);

        // push and pop on the same edge while full
        start = emitted.size();
        force_active = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        check("simul_full_before", int'(o_Full), 1);
        force_active = 1'b0;
        push_byte(8'hBB);
        check("simul_count", int'(o_Count), DEPTH);
        check("simul_ovf",   int'(o_Overflow), 0);
        check("simul_dv",    int'(o_Tx_DV), 1);
        drain(1000);
        exp.delete();
        for (int i = 0; i < DEPTH; i++) exp.push_back(8'h20 + 8'(i));
        exp.push_back(8'hBB);
        check_emitted("simul_emit", start, exp);

        // overflow: 16 accepted, 17th dropped
        start = emitted.size();
        force_active = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        push_byte(8'hAA);
        check("ovf_full",  int'(o_Full), 1);
        check("ovf_flag",  int'(o_Overflow), 1);
        check("ovf_count", int'(o_Count), 16);
        force_active = 1'b0;
        drain(1000);
        exp.delete();
        for (int i = 0; i < DEPTH; i++) exp.push_back(8'h10 + 8'(i));
        check_emitted("ovf_emit", start, exp);
        check("ovf_sticky", int'(o_Overflow), 1);

        // wrap-around with a realistic 104 clocks/bit transmitter
        do_reset();
        check("wrap_ovf_cleared", int'(o_Overflow), 0);
        frame_len = 1040;
        start = emitted.size();
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i));
            repeat (1099) @(negedge clk);
        end
        drain(3000);
        exp.delete();
        for (int i = 0; i < 40; i++) exp.push_back(8'(i));
        check_emitted("wrap_emit", start, exp);
        check("wrap_ovf", int'(o_Overflow), 0);

        // reset in WAIT_DONE with three entries queued
        frame_len = 50;
        force_active = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
        force_active = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_count_before", int'(o_Count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dv",    int'(o_Tx_DV), 0);
        check("midrst_byte",  int'(o_Tx_Byte), 8'h00);
        check("midrst_count", int'(o_Count), 0);
        check("midrst_empty", int'(o_Empty), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_Tx_DV) pulses++;
        end
        check("midrst_no_dv", pulses, 0);
        start = emitted.size();
        push_byte(8'h66);
        drain(300);
        exp = '{8'h66};
        check_emitted("midrst_emit", start, exp);

        // randomized soak: bursty pushes, busy overrides, spurious done pulses
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) frame_len = $urandom_range(20, 2);
            i_Rx_DV      = ($urandom_range(3, 0) == 0);
            i_Rx_Byte    = 8'($urandom);
            spur_done    = ($urandom_range(40, 0) == 0);
            if ($urandom_range(30, 0) == 0) force_active = ~force_active;
            @(negedge clk);
        end
        i_Rx_DV = 1'b0;
        spur_done = 1'b0;
        force_active = 1'b0;
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
